// File: rtl/ram8_fifo_ctrl_if.sv
// Handshake and RAM8 port bundle for ram8_fifo_ctrl.
// Error flag signals exist only when RAM8_FIFO_ERR_EN is defined.
interface ram8_fifo_ctrl_if;
    logic        push_valid;
    logic        push_ready;
    logic [15:0] push_data;
    logic        pop_valid;
    logic        pop_ready;
    logic [15:0] pop_data;
    logic [2:0]  ram_addr;
    logic [15:0] ram_in;
    logic        ram_write;
    logic [15:0] ram_out;
    logic [3:0]  count;
    logic        full;
    logic        empty;
`ifdef RAM8_FIFO_ERR_EN
    logic        overflow_err;
    logic        underflow_err;
`endif

    // Producer, consumer and RAM8 side.
    modport master (
        output push_valid, push_data, pop_ready, ram_out,
        input  push_ready, pop_valid, pop_data, ram_addr, ram_in, ram_write,
        input  count, full, empty
`ifdef RAM8_FIFO_ERR_EN
        , input overflow_err, underflow_err
`endif
    );

    // Controller side.
    modport slave (
        input  push_valid, push_data, pop_ready, ram_out,
        output push_ready, pop_valid, pop_data, ram_addr, ram_in, ram_write,
        output count, full, empty
`ifdef RAM8_FIFO_ERR_EN
        , output overflow_err, underflow_err
`endif
    );
endinterface

// File: rtl/ram8_fifo_ctrl.sv
// Eight-entry 16-bit FIFO controller owning the single RAM8 port, with round-robin push/pop arbitration.
// Optional sticky overflow/underflow flags are built when RAM8_FIFO_ERR_EN is defined.
module ram8_fifo_ctrl (
    input  logic            clk,
    input  logic            reset,
    ram8_fifo_ctrl_if.slave bus
);
    typedef enum logic {
        PREF_POP  = 1'b0,
        PREF_PUSH = 1'b1
    } pref_e;

    logic [2:0] wr_ptr_q, wr_ptr_d;
    logic [2:0] rd_ptr_q, rd_ptr_d;
    logic [3:0] count_q,  count_d;
    pref_e      pref_q,   pref_d;

    logic full, empty;
    logic want_push, want_pop;
    logic grant_push, grant_pop;

    always_comb begin
        full       = (count_q == 4'd8);
        empty      = (count_q == 4'd0);
        want_push  = bus.push_valid & ~full;
        want_pop   = bus.pop_ready & ~empty;
        grant_push = want_push & (~want_pop | (pref_q == PREF_PUSH));
        grant_pop  = want_pop & ~grant_push;
    end

    always_comb begin
        bus.push_ready = ~full & ~(want_pop & (pref_q == PREF_POP));
        bus.pop_valid  = ~empty & ~(want_push & (pref_q == PREF_PUSH));
        // A write in flight while reset is asserted must not reach RAM8.
        bus.ram_write  = grant_push & ~reset;
        bus.ram_addr   = grant_push ? wr_ptr_q : rd_ptr_q;
        bus.ram_in     = bus.push_data;
        bus.pop_data   = bus.ram_out;
        bus.count      = count_q;
        bus.full       = full;
        bus.empty      = empty;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pref_d   = pref_q;
        if (grant_push) begin
            wr_ptr_d = wr_ptr_q + 3'd1;
            count_d  = count_q + 4'd1;
        end else if (grant_pop) begin
            rd_ptr_d = rd_ptr_q + 3'd1;
            count_d  = count_q - 4'd1;
        end
        // Preference moves to the loser only when both sides contend.
        if (want_push & want_pop)
            pref_d = grant_push ? PREF_POP : PREF_PUSH;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= 3'd0;
            rd_ptr_q <= 3'd0;
            count_q  <= 4'd0;
            pref_q   <= PREF_POP;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pref_q   <= pref_d;
        end
    end

`ifdef RAM8_FIFO_ERR_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.push_valid & full)
                overflow_q <= 1'b1;
            if (bus.pop_ready & empty)
                underflow_q <= 1'b1;
        end
    end

    always_comb begin
        bus.overflow_err  = overflow_q;
        bus.underflow_err = underflow_q;
    end
`endif
endmodule

// File: tb/tb_ram8_fifo_ctrl.sv
// Directed self-checking bench for ram8_fifo_ctrl with a behavioural RAM8 attached.
// Error flag checks are compiled in when RAM8_FIFO_ERR_EN is defined.
module tb_ram8_fifo_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ram8_fifo_ctrl_if bus ();

    ram8_fifo_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Behavioural RAM8: synchronous write, combinational read.
    logic [15:0] mem [8];
    always @(posedge clk)
        if (bus.ram_write) mem[bus.ram_addr] <= bus.ram_in;
    assign bus.ram_out = mem[bus.ram_addr];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.push_valid = 1'b0;
        bus.push_data  = 16'h0000;
        bus.pop_ready  = 1'b0;
    endtask

    task automatic test_reset;
        idle();
        reset = 1'b1;
        #12;
        checks++;
        if (bus.push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready got %b want 1", bus.push_ready); end
        checks++;
        if (bus.pop_valid !== 1'b0) begin errors++; $display("FAIL reset_pop_valid got %b want 0", bus.pop_valid); end
        checks++;
        if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
        checks++;
        if (bus.full !== 1'b0 || bus.empty !== 1'b1) begin errors++; $display("FAIL reset_flags got full=%b empty=%b want 0/1", bus.full, bus.empty); end
        checks++;
        if (bus.ram_write !== 1'b0 || bus.ram_addr !== 3'd0) begin errors++; $display("FAIL reset_ram got write=%b addr=%0d want 0/0", bus.ram_write, bus.ram_addr); end
`ifdef RAM8_FIFO_ERR_EN
        checks++;
        if (bus.overflow_err !== 1'b0 || bus.underflow_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b%b want 00", bus.overflow_err, bus.underflow_err); end
`endif
        @(negedge clk);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fill;
        for (int i = 0; i < 8; i++) begin
            bus.push_valid = 1'b1;
            bus.push_data  = 16'h1111 * 16'(i + 1);
            bus.pop_ready  = 1'b0;
            #1;
            checks++;
            if (bus.push_ready !== 1'b1 || bus.ram_write !== 1'b1 || bus.ram_addr !== 3'(i)) begin
                errors++;
                $display("FAIL fill_port[%0d] got ready=%b write=%b addr=%0d want 1/1/%0d", i, bus.push_ready, bus.ram_write, bus.ram_addr, i);
            end
            tick();
            checks++;
            if (bus.count !== 4'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d want %0d", i, bus.count, i + 1); end
        end
        checks++;
        if (bus.full !== 1'b1 || bus.empty !== 1'b0) begin errors++; $display("FAIL fill_full got full=%b empty=%b want 1/0", bus.full, bus.empty); end
        bus.push_data = 16'h9999;
        #1;
        checks++;
        if (bus.push_ready !== 1'b0 || bus.ram_write !== 1'b0) begin errors++; $display("FAIL fill_ninth got ready=%b write=%b want 0/0", bus.push_ready, bus.ram_write); end
        tick();
        idle();
        checks++;
        if (bus.count !== 4'd8) begin errors++; $display("FAIL fill_hold_count got %0d want 8", bus.count); end
`ifdef RAM8_FIFO_ERR_EN
        checks++;
        if (bus.overflow_err !== 1'b1) begin errors++; $display("FAIL overflow_err got %b want 1", bus.overflow_err); end
`endif
    endtask

    task automatic test_drain;
        for (int i = 0; i < 8; i++) begin
            bus.pop_ready = 1'b1;
            #1;
            checks++;
            if (bus.pop_valid !== 1'b1 || bus.pop_data !== 16'h1111 * 16'(i + 1) || bus.ram_write !== 1'b0) begin
                errors++;
                $display("FAIL drain[%0d] got valid=%b data=%h write=%b want 1/%h/0", i, bus.pop_valid, bus.pop_data, bus.ram_write, 16'h1111 * 16'(i + 1));
            end
            tick();
        end
        idle();
        #1;
        checks++;
        if (bus.empty !== 1'b1 || bus.pop_valid !== 1'b0 || bus.count !== 4'd0) begin
            errors++;
            $display("FAIL drain_end got empty=%b valid=%b count=%0d want 1/0/0", bus.empty, bus.pop_valid, bus.count);
        end
        tick();
    endtask

    task automatic push_word(input logic [15:0] data, input logic [2:0] exp_addr, input string tag);
        bus.push_valid = 1'b1;
        bus.push_data  = data;
        bus.pop_ready  = 1'b0;
        #1;
        checks++;
        if (bus.ram_write !== 1'b1 || bus.ram_addr !== exp_addr) begin
            errors++;
            $display("FAIL %s_push got write=%b addr=%0d want 1/%0d", tag, bus.ram_write, bus.ram_addr, exp_addr);
        end
        tick();
        idle();
    endtask

    task automatic pop_word(input logic [15:0] exp_data, input logic [2:0] exp_addr, input string tag);
        bus.push_valid = 1'b0;
        bus.pop_ready  = 1'b1;
        #1;
        checks++;
        if (bus.pop_valid !== 1'b1 || bus.pop_data !== exp_data || bus.ram_addr !== exp_addr) begin
            errors++;
            $display("FAIL %s_pop got valid=%b data=%h addr=%0d want 1/%h/%0d", tag, bus.pop_valid, bus.pop_data, bus.ram_addr, exp_data, exp_addr);
        end
        tick();
        idle();
    endtask

    task automatic test_wrap;
        // Pointers start at 0 after a full fill/drain cycle.
        for (int i = 0; i < 5; i++) push_word(16'h0050 + 16'(i), 3'(i), "wrap_pre");
        for (int i = 0; i < 5; i++) pop_word(16'h0050 + 16'(i), 3'(i), "wrap_pre");
        for (int i = 0; i < 6; i++) push_word(16'h00A0 + 16'(i), 3'(5 + i), "wrap");
        for (int i = 0; i < 6; i++) pop_word(16'h00A0 + 16'(i), 3'(5 + i), "wrap");
        checks++;
        if (bus.count !== 4'd0) begin errors++; $display("FAIL wrap_count got %0d want 0", bus.count); end
    endtask

    task automatic test_contention;
        logic [15:0] exp_pop [2];
        exp_pop[0] = 16'h00C0;
        exp_pop[1] = 16'h00C1;
        // rd_ptr = wr_ptr = 3 here.
        push_word(16'h00C0, 3'd3, "cont_pre");
        push_word(16'h00C1, 3'd4, "cont_pre");
        push_word(16'h00C2, 3'd5, "cont_pre");
        for (int c = 0; c < 4; c++) begin
            bus.push_valid = 1'b1;
            bus.pop_ready  = 1'b1;
            bus.push_data  = 16'h00D0 + 16'(c);
            #1;
            checks++;
            if (c % 2 == 0) begin
                if (bus.pop_valid !== 1'b1 || bus.push_ready !== 1'b0 || bus.ram_write !== 1'b0 ||
                    bus.pop_data !== exp_pop[c / 2] || bus.ram_addr !== 3'(3 + c / 2)) begin
                    errors++;
                    $display("FAIL cont_pop[%0d] got pv=%b pr=%b wr=%b data=%h addr=%0d want 1/0/0/%h/%0d", c,
                             bus.pop_valid, bus.push_ready, bus.ram_write, bus.pop_data, bus.ram_addr, exp_pop[c / 2], 3 + c / 2);
                end
            end else begin
                if (bus.pop_valid !== 1'b0 || bus.push_ready !== 1'b1 || bus.ram_write !== 1'b1 ||
                    bus.ram_addr !== 3'(6 + c / 2)) begin
                    errors++;
                    $display("FAIL cont_push[%0d] got pv=%b pr=%b wr=%b addr=%0d want 0/1/1/%0d", c,
                             bus.pop_valid, bus.push_ready, bus.ram_write, bus.ram_addr, 6 + c / 2);
                end
            end
            tick();
        end
        idle();
        checks++;
        if (bus.count !== 4'd3) begin errors++; $display("FAIL cont_count got %0d want 3", bus.count); end
    endtask

    task automatic test_reset_midstream;
        push_word(16'h00E0, 3'd0, "rst_pre");
        push_word(16'h00E1, 3'd1, "rst_pre");
        checks++;
        if (bus.count !== 4'd5) begin errors++; $display("FAIL rst_pre_count got %0d want 5", bus.count); end
        bus.push_valid = 1'b1;
        bus.push_data  = 16'h7777;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.pop_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got count=%0d empty=%b valid=%b want 0/1/0", bus.count, bus.empty, bus.pop_valid);
        end
        checks++;
        if (bus.ram_write !== 1'b0) begin errors++; $display("FAIL rst_mid_write got %b want 0", bus.ram_write); end
        tick();
        idle();
        @(negedge clk);
        reset = 1'b0;
        tick();
        push_word(16'hBEEF, 3'd0, "rst_post");
        pop_word(16'hBEEF, 3'd0, "rst_post");
    endtask

    task automatic test_underflow;
        bus.pop_ready = 1'b1;
        #1;
        checks++;
        if (bus.pop_valid !== 1'b0 || bus.ram_write !== 1'b0) begin errors++; $display("FAIL under_port got valid=%b write=%b want 0/0", bus.pop_valid, bus.ram_write); end
        tick();
        idle();
        checks++;
        if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin errors++; $display("FAIL under_count got %0d empty=%b want 0/1", bus.count, bus.empty); end
`ifdef RAM8_FIFO_ERR_EN
        checks++;
        if (bus.underflow_err !== 1'b1) begin errors++; $display("FAIL underflow_err got %b want 1", bus.underflow_err); end
        tick();
        checks++;
        if (bus.underflow_err !== 1'b1) begin errors++; $display("FAIL underflow_sticky got %b want 1", bus.underflow_err); end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.underflow_err !== 1'b0) begin errors++; $display("FAIL underflow_clear got %b want 0", bus.underflow_err); end
        @(negedge clk);
        reset = 1'b0;
        tick();
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_contention();
        test_reset_midstream();
        test_underflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
